// File: rtl/elastic_source.sv
// elastic_source: emits a burst of len_i incrementing words from base_i
// over a valid/ready handshake, with an optional trailing XOR checksum beat.
//
// Ports:
//   clk_i, reset_i (async, active-high)
//   start_i, base_i[width_p], len_i[count_width_p] : burst request (IDLE only)
//   ready_i                                        : consumer accepts a beat
//   valid_o, data_o[width_p], last_o               : beat output
//   busy_o                                         : not IDLE
//   done_o                                         : one-cycle completion pulse
//
// Define ELASTIC_SOURCE_CHECKSUM_EN to append one checksum beat
// (XOR of all data beats) to every non-empty burst.

module elastic_source #(
  parameter int width_p       = 10,
  parameter int count_width_p = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     start_i,
  input  logic [width_p-1:0]       base_i,
  input  logic [count_width_p-1:0] len_i,
  input  logic                     ready_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     valid_o,
  output logic [width_p-1:0]       data_o,
  output logic                     last_o
);

`ifdef ELASTIC_SOURCE_CHECKSUM_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
  } state_e;
`endif

  localparam logic [count_width_p-1:0] cnt_one_c = count_width_p'(1);
  localparam logic [width_p-1:0]       data_one_c = width_p'(1);

  state_e                   state_q, state_d;
  logic [width_p-1:0]       data_q, data_d;
  logic [count_width_p-1:0] cnt_q, cnt_d;
  logic                     done_q, done_d;
  logic                     xfer;

`ifdef ELASTIC_SOURCE_CHECKSUM_EN
  logic [width_p-1:0]       csum_q, csum_d;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef ELASTIC_SOURCE_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef ELASTIC_SOURCE_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign xfer = valid_o & ready_i;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
`ifdef ELASTIC_SOURCE_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d = SEND;
            data_d  = base_i;
            cnt_d   = len_i;
`ifdef ELASTIC_SOURCE_CHECKSUM_EN
            csum_d  = '0;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SEND: begin
        if (xfer) begin
          if (cnt_q == cnt_one_c) begin
            cnt_d = '0;
`ifdef ELASTIC_SOURCE_CHECKSUM_EN
            // Fold the final data beat in while loading the checksum beat.
            state_d = CSUM;
            data_d  = csum_q ^ data_q;
            csum_d  = '0;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_d  = cnt_q - cnt_one_c;
            data_d = data_q + data_one_c;
`ifdef ELASTIC_SOURCE_CHECKSUM_EN
            csum_d = csum_q ^ data_q;
`endif
          end
        end
      end
`ifdef ELASTIC_SOURCE_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // All outputs decode from registered state; none looks at ready_i.
  assign valid_o = (state_q != IDLE);
  assign busy_o  = (state_q != IDLE);
  assign done_o  = done_q;
  assign data_o  = data_q;

`ifdef ELASTIC_SOURCE_CHECKSUM_EN
  assign last_o = (state_q == CSUM);
`else
  assign last_o = (state_q == SEND) && (cnt_q == cnt_one_c);
`endif

endmodule
